// File: rtl/control_mult_matrices_pkg.sv
// Shared definitions for the matrix-product sequencer: state encoding,
// error codes and the select-width helper.
package control_mult_matrices_pkg;

    typedef enum logic [3:0] {
        REPOSO = 4'd0,
        CARGA  = 4'd1,
        INICIO = 4'd2,
        ESPERA = 4'd3,
        GUARDA = 4'd4,
        LIMPIA = 4'd5,
        AVANZA = 4'd6,
        FIN    = 4'd7,
        FALLA  = 4'd8
    } estado_t;

    localparam logic [1:0] COD_NINGUNO = 2'b00;
    localparam logic [1:0] COD_INERROR = 2'b01;
    localparam logic [1:0] COD_TIMEOUT = 2'b10;

    // Select width for n items; never narrower than one bit.
    function automatic int ancho(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/control_mult_matrices_if.sv
// Handshake bundle between the sequencer (slave side) and the
// requester/datapath environment (master side).
interface control_mult_matrices_if
    import control_mult_matrices_pkg::*;
#(
    parameter int FILAS    = 4,
    parameter int COLUMNAS = 4
);
    localparam int WF = ancho(FILAS);
    localparam int WC = ancho(COLUMNAS);

    logic                         Enable;
    logic                         Start;
    logic                         ListoIn;
    logic                         InError;
    logic                         EnableIn;
    logic                         StartCalculo;
    logic                         ResetCalculo;
    logic [WF-1:0]                SELMUXFila;
    logic [WC-1:0]                SELMUXColumna;
    logic [FILAS*COLUMNAS-1:0]    EnableRegisterOut;
    logic                         Ocupado;
    logic                         Listo;
    logic                         Error;
    logic [1:0]                   CodigoError;

    modport master (
        output Enable, Start, ListoIn, InError,
        input  EnableIn, StartCalculo, ResetCalculo, SELMUXFila, SELMUXColumna,
               EnableRegisterOut, Ocupado, Listo, Error, CodigoError
    );

    modport slave (
        input  Enable, Start, ListoIn, InError,
        output EnableIn, StartCalculo, ResetCalculo, SELMUXFila, SELMUXColumna,
               EnableRegisterOut, Ocupado, Listo, Error, CodigoError
    );

endinterface

// File: rtl/control_mult_matrices_contador.sv
// Row/column walk over the result matrix in row-major order, wrapping both
// counters to zero after the last element.
module contador_fila_columna
    import control_mult_matrices_pkg::*;
#(
    parameter int FILAS    = 4,
    parameter int COLUMNAS = 4,
    localparam int WF      = ancho(FILAS),
    localparam int WC      = ancho(COLUMNAS)
)(
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [WF-1:0] fila_o,
    output logic [WC-1:0] columna_o,
    output logic          ultimo_o
);

    localparam logic [WF-1:0] FILA_MAX = WF'(FILAS - 1);
    localparam logic [WC-1:0] COL_MAX  = WC'(COLUMNAS - 1);

    logic [WF-1:0] fila_q, fila_d;
    logic [WC-1:0] col_q, col_d;

    // Next counter values: clear has priority over advance.
    always_comb begin
        fila_d = fila_q;
        col_d  = col_q;
        if (clr_i) begin
            fila_d = {WF{1'b0}};
            col_d  = {WC{1'b0}};
        end else if (inc_i) begin
            if (col_q == COL_MAX) begin
                col_d  = {WC{1'b0}};
                fila_d = (fila_q == FILA_MAX) ? {WF{1'b0}} : fila_q + WF'(1);
            end else begin
                col_d  = col_q + WC'(1);
            end
        end else begin
            fila_d = fila_q;
            col_d  = col_q;
        end
    end

    // Counter registers; hold whenever the global enable is low.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fila_q <= {WF{1'b0}};
            col_q  <= {WC{1'b0}};
        end else if (en_i) begin
            fila_q <= fila_d;
            col_q  <= col_d;
        end
    end

    assign fila_o    = fila_q;
    assign columna_o = col_q;
    assign ultimo_o  = (fila_q == FILA_MAX) && (col_q == COL_MAX);

endmodule

// File: rtl/control_mult_matrices.sv
// Sequencer for a full matrix product: walks every result element, launches
// one dot product each, stores the result and reports completion or failure.
module control_mult_matrices
    import control_mult_matrices_pkg::*;
#(
    parameter int FILAS    = 4,
    parameter int COLUMNAS = 4,
    parameter int TIMEOUT  = 1024
)(
    input  logic                   CLK,
    input  logic                   MasterReset,
    control_mult_matrices_if.slave bus
);

    localparam int WF = ancho(FILAS);
    localparam int WC = ancho(COLUMNAS);
    localparam int WT = ancho(TIMEOUT);
    localparam int NE = FILAS * COLUMNAS;
    // Last wait count before giving up: ESPERA lasts TIMEOUT-1 enabled cycles.
    localparam logic [WT-1:0] TMO_LIM = WT'(TIMEOUT - 2);
    localparam logic [NE-1:0] BIT0    = NE'(1);

    estado_t       estado_q, estado_d;
    logic [WT-1:0] tmo_q, tmo_d;
    logic          error_q, error_d;
    logic [1:0]    codigo_q, codigo_d;

    logic          cnt_clr_s, cnt_inc_s, ultimo_s;
    logic [WF-1:0] fila_s;
    logic [WC-1:0] columna_s;
    logic          en_in_s, start_s, rst_calc_s, guarda_s, listo_s;
    int            idx_s;

    contador_fila_columna #(
        .FILAS    (FILAS),
        .COLUMNAS (COLUMNAS)
    ) u_contador (
        .clk_i     (CLK),
        .rst_i     (MasterReset),
        .en_i      (bus.Enable),
        .clr_i     (cnt_clr_s),
        .inc_i     (cnt_inc_s),
        .fila_o    (fila_s),
        .columna_o (columna_s),
        .ultimo_o  (ultimo_s)
    );

    // State, timeout and sticky error registers; advance only on enabled cycles.
    always_ff @(posedge CLK or posedge MasterReset) begin
        if (MasterReset) begin
            estado_q <= REPOSO;
            tmo_q    <= {WT{1'b0}};
            error_q  <= 1'b0;
            codigo_q <= COD_NINGUNO;
        end else if (bus.Enable) begin
            estado_q <= estado_d;
            tmo_q    <= tmo_d;
            error_q  <= error_d;
            codigo_q <= codigo_d;
        end
    end

    // Next-state and per-state output decode.
    always_comb begin
        estado_d   = estado_q;
        tmo_d      = tmo_q;
        error_d    = error_q;
        codigo_d   = codigo_q;
        cnt_clr_s  = 1'b0;
        cnt_inc_s  = 1'b0;
        en_in_s    = 1'b0;
        start_s    = 1'b0;
        rst_calc_s = 1'b0;
        guarda_s   = 1'b0;
        listo_s    = 1'b0;
        case (estado_q)
            REPOSO: begin
                rst_calc_s = 1'b1;
                cnt_clr_s  = 1'b1;
                if (bus.Start) begin
                    estado_d = CARGA;
                    error_d  = 1'b0;
                    codigo_d = COD_NINGUNO;
                end else begin
                    estado_d = REPOSO;
                end
            end
            CARGA: begin
                en_in_s  = 1'b1;
                estado_d = INICIO;
            end
            INICIO: begin
                start_s  = 1'b1;
                tmo_d    = {WT{1'b0}};
                estado_d = ESPERA;
            end
            ESPERA: begin
                // A datapath error outranks a simultaneous completion.
                if (bus.InError) begin
                    estado_d = FALLA;
                    error_d  = 1'b1;
                    codigo_d = COD_INERROR;
                end else if (bus.ListoIn) begin
                    estado_d = GUARDA;
                end else if (tmo_q == TMO_LIM) begin
                    estado_d = FALLA;
                    error_d  = 1'b1;
                    codigo_d = COD_TIMEOUT;
                end else begin
                    tmo_d = tmo_q + WT'(1);
                end
            end
            GUARDA: begin
                guarda_s = 1'b1;
                estado_d = LIMPIA;
            end
            LIMPIA: begin
                rst_calc_s = 1'b1;
                estado_d   = AVANZA;
            end
            AVANZA: begin
                cnt_inc_s = 1'b1;
                estado_d  = ultimo_s ? FIN : INICIO;
            end
            FIN: begin
                listo_s  = 1'b1;
                estado_d = REPOSO;
            end
            FALLA: begin
                rst_calc_s = 1'b1;
                cnt_clr_s  = 1'b1;
                estado_d   = REPOSO;
            end
            default: begin
                cnt_clr_s = 1'b1;
                estado_d  = REPOSO;
            end
        endcase
    end

    assign idx_s = int'(fila_s) * COLUMNAS + int'(columna_s);

    assign bus.EnableIn          = en_in_s;
    assign bus.StartCalculo      = start_s;
    assign bus.ResetCalculo      = rst_calc_s;
    assign bus.EnableRegisterOut = guarda_s ? (BIT0 << idx_s) : {NE{1'b0}};
    assign bus.Ocupado           = (estado_q != REPOSO);
    assign bus.Listo             = listo_s;
    assign bus.Error             = error_q;
    assign bus.CodigoError       = codigo_q;
    assign bus.SELMUXFila        = fila_s;
    assign bus.SELMUXColumna     = columna_s;

endmodule

// File: doc/control_mult_matrices.md
CONTROL_MULT_MATRICES -- requirements
Module: control_mult_matrices

Interface
REQ-001 Parameter FILAS, default 4: rows of result matrix; legal range 1..16.
REQ-002 Parameter COLUMNAS, default 4: columns of result matrix; legal range 1..16.
REQ-003 Parameter TIMEOUT, default 1024: maximum wait cycles for ListoIn; legal range ≥2.
REQ-004 Derived constants: WF = max(1, clog2(FILAS)); WC = max(1, clog2(COLUMNAS)).
REQ-005 Port CLK, in, 1: single clock, rising edge.
REQ-006 Port MasterReset, in, 1: asynchronous, active-high reset.
REQ-007 Port Enable, in, 1: global advance qualifier.
REQ-008 Port Start, in, 1: request one full matrix product.
REQ-009 Port ListoIn, in, 1: dot-product datapath finished.
REQ-010 Port InError, in, 1: datapath overflow/underflow.
REQ-011 Port EnableIn, out, 1: load input matrices.
REQ-012 Port StartCalculo, out, 1: start one dot product.
REQ-013 Port ResetCalculo, out, 1: clear dot-product datapath.
REQ-014 Port SELMUXFila, out, WF: row select of matrix A.
REQ-015 Port SELMUXColumna, out, WC: column select of matrix B.
REQ-016 Port EnableRegisterOut, out, FILAS*COLUMNAS: one-hot result write enable; bit index = fila*COLUMNAS + columna.
REQ-017 Port Ocupado, out, 1: product in progress.
REQ-018 Port Listo, out, 1: product complete.
REQ-019 Port Error, out, 1: sticky error flag.
REQ-020 Port CodigoError, out, 2: 01 = InError, 10 = timeout, 00 = none.

Function
REQ-021 States: REPOSO, CARGA, INICIO, ESPERA, GUARDA, LIMPIA, AVANZA, FIN, FALLA.
REQ-022 The state register, fila/columna counters and timeout counter update only on cycles with Enable=1; otherwise they hold.
REQ-023 Outputs EnableIn, StartCalculo, ResetCalculo, EnableRegisterOut, Ocupado and Listo decode combinationally from state; with Enable=0 they hold.
REQ-024 REPOSO: ResetCalculo=1, counters held at 0; on Start=1 go to CARGA, clear Error and CodigoError.
REQ-025 CARGA: EnableIn=1; go to INICIO.
REQ-026 INICIO: StartCalculo=1; clear timeout counter; go to ESPERA.
REQ-027 ESPERA: InError=1 goes to FALLA with CodigoError=01; else ListoIn=1 goes to GUARDA; else the timeout counter increments; at count TIMEOUT-1 go to FALLA with CodigoError=10.
REQ-028 InError and ListoIn asserted in the same ESPERA cycle: InError wins.
REQ-029 GUARDA: exactly one EnableRegisterOut bit (current fila, columna) =1; go to LIMPIA.
REQ-030 LIMPIA: ResetCalculo=1; go to AVANZA.
REQ-031 AVANZA, last element (fila=FILAS-1, columna=COLUMNAS-1): go to FIN with counters wrapped to 0.
REQ-032 AVANZA, otherwise: if columna=COLUMNAS-1, columna wraps to 0 and fila increments; else columna increments; go to INICIO.
REQ-033 FIN: Listo=1 for one enabled cycle; go to REPOSO.
REQ-034 FALLA: ResetCalculo=1, Error set; go to REPOSO; counters cleared.
REQ-035 Ocupado=1 in every state except REPOSO.
REQ-036 Start outside REPOSO is ignored.
REQ-037 Error and CodigoError remain set until the next accepted Start or reset.
REQ-038 Unreachable state encodings recover to REPOSO on the next enabled cycle.
REQ-039 Latency of an error-free product, Enable held 1 and ListoIn returned k cycles after StartCalculo: 2 + FILAS*COLUMNAS*(k+4) + 1 cycles from Start to Listo.

Reset
REQ-040 On MasterReset=1, state = REPOSO, counters = 0, Error = 0, CodigoError = 00, independent of CLK and Enable.
REQ-041 Output values during reset: ResetCalculo=1; all other outputs 0.
REQ-042 Reset asserted mid-product abandons the product; no Listo is issued.

Structure
REQ-043 A shared package holds the state encoding, the CodigoError values and the WF/WC width function.
REQ-044 Sub-module contador_fila_columna (parameters FILAS, COLUMNAS) holds the two wrap-around counters and the last-element flag; the FSM and timeout counter stay top-level.

Verification
REQ-045 FILAS=COLUMNAS=4, ListoIn 3 cycles after each StartCalculo -> 16 GUARDA pulses at indices 0..15 in order; Listo at cycle 2+16*7+1=115 after Start.
REQ-046 FILAS=2, COLUMNAS=3 -> EnableRegisterOut bits 0,1,2,3,4,5 in order; SELMUXFila goes 0,0,0,1,1,1.
REQ-047 InError and ListoIn together at element 5 -> FALLA, Error=1, CodigoError=01, no bit 5 write; next Start clears Error.
REQ-048 TIMEOUT=8, ListoIn never asserted -> FALLA 8 cycles after INICIO with CodigoError=10.
REQ-049 Enable dropped for 5 cycles in ESPERA -> state, counters and outputs frozen; timeout counter does not advance.
REQ-050 MasterReset pulsed mid-product, asynchronously between edges -> immediate REPOSO outputs, no Listo; Start afterwards begins at element 0.
